// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and helpers for the 7-segment scan display
package fnd_pkg;

  localparam int FND_DIGITS = 4;
  localparam int DP_BIT     = 7;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}, decimal point off
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  // Largest value four decimal digits can show
  localparam logic [13:0] VALUE_MAX = 14'd9999;

  function automatic logic [13:0] sat_value(input logic [13:0] v);
    return (v > VALUE_MAX) ? VALUE_MAX : v;
  endfunction

  function automatic logic [7:0] font_of(input logic [3:0] d);
    case (d)
      4'd0:    return FONT_0;
      4'd1:    return FONT_1;
      4'd2:    return FONT_2;
      4'd3:    return FONT_3;
      4'd4:    return FONT_4;
      4'd5:    return FONT_5;
      4'd6:    return FONT_6;
      4'd7:    return FONT_7;
      4'd8:    return FONT_8;
      4'd9:    return FONT_9;
      default: return FONT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// rtl/fnd_tick_gen.sv - free-running prescaler producing a one-cycle tick every DIV clocks
module fnd_tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Count 0..DIV-1 and wrap; tick marks the last count of each period
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register, cleared asynchronously so a reset restarts a full period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit multiplexed common-anode 7-segment driver
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLANK_LZ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] count_data,
  input  logic [3:0]  dp_en,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont
);

  localparam int DIV = CLK_HZ / SCAN_HZ;

  logic                        tick;
  logic [1:0]                  sel_q, sel_d;
  logic [3:0]                  com_q, com_d;
  logic [7:0]                  font_q, font_d;
  logic [13:0]                 value;
  logic [FND_DIGITS-1:0][3:0]  digit;
  logic [FND_DIGITS-1:0]       blank;

  fnd_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Clamp to the displayable range and split into decimal digits
  always_comb begin
    value    = sat_value(count_data);
    digit[0] = 4'(value % 14'd10);
    digit[1] = 4'((value / 14'd10) % 14'd10);
    digit[2] = 4'((value / 14'd100) % 14'd10);
    digit[3] = 4'(value / 14'd1000);
  end

  // Leading-zero suppression: a digit blanks only when it and every higher digit are zero
  always_comb begin
    blank = '0;
    if (BLANK_LZ != 0) begin
      blank[3] = (digit[3] == 4'd0);
      blank[2] = (digit[3] == 4'd0) && (digit[2] == 4'd0);
      blank[1] = (digit[3] == 4'd0) && (digit[2] == 4'd0) && (digit[1] == 4'd0);
    end
  end

  // Next digit select and the common/segment pattern for that digit
  always_comb begin
    sel_d          = tick ? sel_q + 2'd1 : sel_q;
    com_d          = ~(4'b0001 << sel_d);
    font_d         = blank[sel_d] ? FONT_BLANK : font_of(digit[sel_d]);
    font_d[DP_BIT] = ~dp_en[sel_d];
  end

  // Select and both outputs update on the same edge so commons and segments never skew
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= 2'd0;
      com_q  <= 4'b1111;
      font_q <= FONT_BLANK;
    end else begin
      sel_q  <= sel_d;
      com_q  <= com_d;
      font_q <= font_d;
    end
  end

  assign fndCom  = com_q;
  assign fndFont = font_q;

endmodule
